// File: rtl/spi_slave_core.sv
// SPI target engine: oversamples SCK/NSS/MOSI in the clk_i domain, shifts MISO out of a
// one-entry transmit buffer and assembles 8/16/24/32-bit receive words.
module spi_slave_core #(
    parameter int SYNC_STAGES = 2,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cpol_i,
    input  logic                  cpha_i,
    input  logic                  lsb_i,
    input  logic [1:0]            dtb_i,
    input  logic                  spi_sck_i,
    input  logic                  spi_nss_i,
    input  logic                  spi_mosi_i,
    output logic                  spi_miso_o,
    output logic                  spi_miso_oe_o,
    input  logic [DATA_WIDTH-1:0] tx_data_i,
    input  logic                  tx_valid_i,
    output logic                  tx_ready_o,
    output logic [DATA_WIDTH-1:0] rx_data_o,
    output logic                  rx_valid_o,
    output logic                  tx_underrun_o,
    output logic                  busy_o
);
    localparam int CW = $clog2(DATA_WIDTH) + 1;

    typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;
    state_t state;

    logic [SYNC_STAGES-1:0] sck_sync, nss_sync, mosi_sync;
    logic sck_d, nss_d;
    logic sck_s, nss_s, mosi_s;
    logic cfg_cpol, cfg_cpha, cfg_lsb;
    logic [1:0] cfg_dtb;
    logic tx_full, load_pending;
    logic [DATA_WIDTH-1:0] tx_buf, shift_tx, rx_shift, rx_next, load_word;
    logic [CW-1:0] rx_cnt, tx_cnt, n_cfg, n_in, rx_pos;
    logic nss_fall, nss_rise, lead_edge, trail_edge, sample_edge, shift_edge;

    function automatic logic [CW-1:0] frame_len(input logic [1:0] dtb);
        return CW'({dtb, 3'b000}) + CW'(8);
    endfunction

    // Bit number idx of the transmit order (MSB-first or LSB-first) within an n-bit frame.
    function automatic logic pick_bit(input logic [DATA_WIDTH-1:0] w, input logic [CW-1:0] idx,
                                      input logic lsb, input logic [CW-1:0] n);
        logic [CW-1:0] pos;
        pos = lsb ? idx : (n - idx - CW'(1));
        return |(w & (DATA_WIDTH'(1) << pos));
    endfunction

    assign sck_s  = sck_sync[SYNC_STAGES-1];
    assign nss_s  = nss_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    assign nss_fall    = nss_d & ~nss_s;
    assign nss_rise    = ~nss_d & nss_s;
    assign lead_edge   = (sck_d == cfg_cpol) && (sck_s != cfg_cpol);
    assign trail_edge  = (sck_d != cfg_cpol) && (sck_s == cfg_cpol);
    assign sample_edge = cfg_cpha ? trail_edge : lead_edge;
    assign shift_edge  = cfg_cpha ? lead_edge : trail_edge;

    assign n_cfg     = frame_len(cfg_dtb);
    assign n_in      = frame_len(dtb_i);
    assign load_word = tx_full ? tx_buf : '0;

    always_comb begin
        rx_pos  = cfg_lsb ? rx_cnt : (n_cfg - rx_cnt - CW'(1));
        rx_next = rx_shift | (DATA_WIDTH'(mosi_s) << rx_pos);
    end

    // NSS history resets low so a select already asserted at release is not seen as a fall.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sck_sync  <= '0;
            nss_sync  <= '0;
            mosi_sync <= '0;
            sck_d     <= 1'b0;
            nss_d     <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck_i};
            nss_sync  <= {nss_sync[SYNC_STAGES-2:0], spi_nss_i};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi_i};
            sck_d     <= sck_s;
            nss_d     <= nss_s;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= IDLE;
            cfg_cpol      <= 1'b0;
            cfg_cpha      <= 1'b0;
            cfg_lsb       <= 1'b0;
            cfg_dtb       <= 2'b00;
            tx_full       <= 1'b0;
            tx_buf        <= '0;
            shift_tx      <= '0;
            rx_shift      <= '0;
            rx_cnt        <= '0;
            tx_cnt        <= '0;
            load_pending  <= 1'b0;
            spi_miso_o    <= 1'b0;
            spi_miso_oe_o <= 1'b0;
            rx_data_o     <= '0;
            rx_valid_o    <= 1'b0;
            tx_underrun_o <= 1'b0;
        end else begin
            rx_valid_o    <= 1'b0;
            tx_underrun_o <= 1'b0;
            if (tx_valid_i && !tx_full) begin
                tx_buf  <= tx_data_i;
                tx_full <= 1'b1;
            end
            case (state)
                IDLE: begin
                    spi_miso_oe_o <= 1'b0;
                    spi_miso_o    <= 1'b0;
                    rx_cnt        <= '0;
                    tx_cnt        <= '0;
                    load_pending  <= 1'b0;
                    if (nss_fall) begin
                        state         <= ACTIVE;
                        cfg_cpol      <= cpol_i;
                        cfg_cpha      <= cpha_i;
                        cfg_lsb       <= lsb_i;
                        cfg_dtb       <= dtb_i;
                        spi_miso_oe_o <= 1'b1;
                        shift_tx      <= load_word;
                        rx_shift      <= '0;
                        if (tx_full) tx_full <= 1'b0;
                        else         tx_underrun_o <= 1'b1;
                        // cpha=0 must present the first bit before the first sampling edge.
                        if (!cpha_i) begin
                            spi_miso_o <= pick_bit(load_word, '0, lsb_i, n_in);
                            tx_cnt     <= CW'(1);
                        end
                    end
                end
                ACTIVE: begin
                    if (nss_rise) begin
                        state         <= IDLE;
                        spi_miso_oe_o <= 1'b0;
                        spi_miso_o    <= 1'b0;
                        load_pending  <= 1'b0;
                    end else begin
                        if (sample_edge) begin
                            if (rx_cnt == n_cfg - CW'(1)) begin
                                rx_data_o    <= rx_next;
                                rx_valid_o   <= 1'b1;
                                rx_shift     <= '0;
                                rx_cnt       <= '0;
                                load_pending <= 1'b1;
                            end else begin
                                rx_shift <= rx_next;
                                rx_cnt   <= rx_cnt + CW'(1);
                            end
                        end
                        if (shift_edge) begin
                            if (load_pending) begin
                                shift_tx     <= load_word;
                                spi_miso_o   <= pick_bit(load_word, '0, cfg_lsb, n_cfg);
                                tx_cnt       <= CW'(1);
                                load_pending <= 1'b0;
                                if (tx_full) tx_full <= 1'b0;
                                else         tx_underrun_o <= 1'b1;
                            end else begin
                                spi_miso_o <= pick_bit(shift_tx, tx_cnt, cfg_lsb, n_cfg);
                                tx_cnt     <= tx_cnt + CW'(1);
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign tx_ready_o = ~tx_full & ~rst_i;
    assign busy_o     = (state == ACTIVE);
endmodule

// File: doc/spi_slave_core.md
Name: spi_slave_core

Overview:
- SPI target (slave) engine; the far end of the SPI master link.
- Receives MOSI frames and drives MISO from a one-entry transmit buffer.
- Frame length is 8/16/24/32 bits, selected with the same TDTB/RDTB encoding as the master.
- Oversamples SCK/NSS/MOSI in the clk_i domain; sits behind an APB4 register wrapper that supplies configuration and consumes data.

Parameters:
- SYNC_STAGES, 2, synchronizer depth on spi_sck_i, spi_nss_i, spi_mosi_i (legal 2..4).
- DATA_WIDTH, 32, tx/rx word width; fixed equal to SPI data width.

Ports:
- clk_i  in  1  system clock; must be >= 8x SCK frequency.
- rst_i  in  1  synchronous active-high reset.
- cpol_i  in  1  SCK idle level.
- cpha_i  in  1  0: sample on leading edge; 1: sample on trailing edge.
- lsb_i  in  1  1: LSB first.
- dtb_i  in  2  frame size code (00=8, 01=16, 10=24, 11=32 bits).
- spi_sck_i  in  1  serial clock from master.
- spi_nss_i  in  1  active-low select.
- spi_mosi_i  in  1  serial data in.
- spi_miso_o  out  1  serial data out.
- spi_miso_oe_o  out  1  MISO output enable.
- tx_data_i  in  32  word to transmit.
- tx_valid_i  in  1  tx word valid.
- tx_ready_o  out  1  tx buffer empty.
- rx_data_o  out  32  last received word, right-aligned, upper bits zero.
- rx_valid_o  out  1  one-cycle pulse, rx_data_o updated.
- tx_underrun_o  out  1  one-cycle pulse, frame loaded from empty buffer.
- busy_o  out  1  frame in progress (NSS low).

Behaviour:
- Synchronization: SCK, NSS and MOSI each pass through SYNC_STAGES flops. Edges are detected from the last two synced SCK samples, and MOSI is taken from its synced value.
- Edge naming: leading edge = SCK leaving the cpol_i level; trailing edge = the opposite transition. Sample edge = leading if cpha=0, trailing if cpha=1. Shift edge = the other one.
- Frame length: N = 8*(dtb+1).
- Configuration capture: cpol/cpha/lsb/dtb are latched on the synced NSS falling edge and held until NSS rises.
- FSM states IDLE, ACTIVE.
  - IDLE: miso_oe=0, counters cleared.
  - IDLE -> ACTIVE on synced NSS fall. That cycle performs LOAD: shift_tx <= buffer if full (buffer emptied), else 0 with a tx_underrun_o pulse. rx_cnt=0, tx_cnt=0.
  - ACTIVE -> IDLE on synced NSS rise, from any bit position (abort). No rx_valid_o for a partial frame. Partial tx word is discarded. miso_oe=0 the same cycle.
- MISO drive:
  - Bit order: MSB-first sends bit N-1 down to 0; LSB-first sends bit 0 up to N-1.
  - spi_miso_oe_o=1 throughout ACTIVE; spi_miso_o is registered.
  - cpha=0: first bit driven in the LOAD cycle; each shift edge advances to the next bit.
  - cpha=1: spi_miso_o is held at 0 until the first leading edge. That edge drives bit 0 of the order; each later leading edge advances.
- Receive: on each sample edge, the synced MOSI bit is placed at position N-1-rx_cnt (MSB-first) or rx_cnt (LSB-first), then rx_cnt++.
- Frame completion: on the Nth sample edge:
  - next cycle rx_data_o <= assembled word and rx_valid_o=1 for exactly 1 cycle;
  - rx_cnt=0; NSS stays low so frames continue back-to-back.
  - The next shift edge performs LOAD (same underrun rule) and drives the first bit of the next frame instead of advancing.
  - For cpha=1, LOAD happens on the next leading edge, which also drives the first bit.
- rx path has no backpressure; rx_data_o holds until the next completed frame.
- TX buffer handshake:
  - tx_ready_o = buffer empty; a word is accepted when tx_valid_i & tx_ready_o.
  - If LOAD and acceptance fall in the same cycle with the buffer empty: underrun is declared, shift_tx=0, and the accepted word stays buffered for the next frame.
  - Config inputs changing mid-frame have no effect.
- Reset (sync, rst_i=1, any time including mid-frame):
  - FSM to IDLE, buffer emptied, tx_ready_o=0 while rst_i=1 and 1 from the first cycle after.
  - spi_miso_o=0, spi_miso_oe_o=0, rx_data_o=0, rx_valid_o=0, tx_underrun_o=0, busy_o=0.
  - After release, NSS already low is not treated as a falling edge; the block waits for NSS high, then low.
- busy_o = (state==ACTIVE).

Test Plan:
- Mode 0, MSB, dtb=00: buffer 0xA5, master sends 0x3C. Required: MISO bits 1,0,1,0,0,1,0,1; rx_data_o=0x0000003C; one rx_valid_o pulse; tx_ready_o back to 1 after NSS fall.
- Mode 3 (cpol=1, cpha=1), LSB, dtb=11: tx 0x12345678, master sends 0xDEADBEEF. Required: MISO sequence LSB-first of 0x12345678; rx_data_o=0xDEADBEEF.
- Underrun: NSS falls with the buffer empty. Required: tx_underrun_o single pulse, MISO all zeros for 8 bits, rx still captured correctly.
- Back-to-back 16-bit frames, NSS held low: buffer 0x1111, then 0x2222 written during frame 1. Required: two rx_valid_o pulses; MISO is 0x1111 then 0x2222 with no gap bits.
- Abort: NSS rises after 5 of 8 bits. Required: no rx_valid_o, miso_oe=0, busy_o=0; the next frame starts at bit 0 correctly.
- Reset mid-frame (bit 12 of 24): Required: all outputs at reset values, tx_ready_o=1 after release, no rx_valid_o; the next full NSS cycle transfers normally.
